bw_sys_evt_seq: RTL

//  Parametrised jbus-domain system-event sequencer; generalises the fixed warm-reset/ext-int/temp-trig/clk-stretch driver.

---
 rtl/bw_sys_evt_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/bw_sys_evt_seq.sv
// Jbus-domain system-event sequencer: queued (channel, delay, width) commands
// replayed as timed pulses or sticky toggles on NUM_CH sideband outputs.
module bw_sys_evt_seq #(
   parameter int                NUM_CH   = 4,
   parameter int                CH_W     = 2,
   parameter int                DLY_W    = 16,
   parameter int                WID_W    = 8,
   parameter int                QDEPTH   = 4,
   parameter logic [NUM_CH-1:0] IDLE_VAL = NUM_CH'(4'b0001)
) (
   input  logic                      jbus_gclk,
   input  logic                      j_rst,
   input  logic                      arm,
   input  logic                      cmd_vld,
   output logic                      cmd_rdy,
   input  logic [CH_W-1:0]           cmd_ch,
   input  logic [DLY_W-1:0]          cmd_dly,
   input  logic [WID_W-1:0]          cmd_wid,
   output logic [NUM_CH-1:0]         evt_out,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic [$clog2(QDEPTH):0]   q_cnt
);

   localparam int AW    = $clog2(QDEPTH);
   localparam int CNT_W = (DLY_W > WID_W) ? DLY_W : WID_W;
   localparam int ENT_W = CH_W + DLY_W + WID_W;
   localparam logic [CH_W:0] NUM_CH_X = (CH_W+1)'(NUM_CH);

   typedef enum logic [1:0] {IDLE, DELAY, ACTIVE} state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [CH_W-1:0]     cur_ch, cur_ch_nxt;
   logic [WID_W-1:0]    cur_wid, cur_wid_nxt;
   logic [NUM_CH-1:0]   sticky, sticky_nxt;
   logic [NUM_CH-1:0]   pulse_mask, pulse_nxt;
   logic                done_nxt, err_nxt;
   logic                pop, push;
   logic                fire;
   logic [CH_W-1:0]     fire_ch;
   logic [WID_W-1:0]    fire_wid;

   logic [ENT_W-1:0]    fifo_mem [QDEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [AW:0]         fill;
   logic                full, empty;
   logic [CH_W-1:0]     head_ch;
   logic [DLY_W-1:0]    head_dly;
   logic [WID_W-1:0]    head_wid;
   logic                head_bad;

   function automatic logic [NUM_CH-1:0] ch_dec(input logic [CH_W-1:0] ch);
      logic [NUM_CH-1:0] oh;
      oh = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch == CH_W'(i)) oh[i] = 1'b1;
      end
      return oh;
   endfunction

   // Full check uses only the registered fill, so a same-edge pop never frees a slot.
   assign full     = (fill == (AW+1)'(QDEPTH));
   assign empty    = (fill == '0);
   assign cmd_rdy  = !j_rst && !full;
   assign push     = cmd_vld && cmd_rdy;
   assign q_cnt    = fill;
   assign {head_ch, head_dly, head_wid} = fifo_mem[rd_ptr];
   assign head_bad = ({1'b0, head_ch} >= NUM_CH_X);

   always_ff @(posedge jbus_gclk) begin
      if (push) fifo_mem[wr_ptr] <= {cmd_ch, cmd_dly, cmd_wid};
   end

   always_ff @(posedge jbus_gclk or posedge j_rst) begin
      if (j_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fill <= fill + (AW+1)'(1);
            2'b01:   fill <= fill - (AW+1)'(1);
            default: fill <= fill;
         endcase
      end
   end

   always_ff @(posedge jbus_gclk or posedge j_rst) begin
      if (j_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge jbus_gclk or posedge j_rst) begin
      if (j_rst) begin
         cnt        <= '0;
         cur_ch     <= '0;
         cur_wid    <= '0;
         sticky     <= '0;
         pulse_mask <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         cur_ch     <= cur_ch_nxt;
         cur_wid    <= cur_wid_nxt;
         sticky     <= sticky_nxt;
         pulse_mask <= pulse_nxt;
         done       <= done_nxt;
         err        <= err_nxt;
      end
   end

   // A zero-delay pop fires straight from the FIFO head; otherwise DELAY fires from the latched command.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      cur_ch_nxt  = cur_ch;
      cur_wid_nxt = cur_wid;
      sticky_nxt  = sticky;
      pulse_nxt   = pulse_mask;
      done_nxt    = 1'b0;
      err_nxt     = 1'b0;
      pop         = 1'b0;
      fire        = 1'b0;
      fire_ch     = cur_ch;
      fire_wid    = cur_wid;
      case (state)
         IDLE: begin
            if (arm && !empty) begin
               pop = 1'b1;
               if (head_bad) begin
                  err_nxt = 1'b1;
               end else if (head_dly == '0) begin
                  fire     = 1'b1;
                  fire_ch  = head_ch;
                  fire_wid = head_wid;
               end else begin
                  state_nxt   = DELAY;
                  cnt_nxt     = CNT_W'(head_dly);
                  cur_ch_nxt  = head_ch;
                  cur_wid_nxt = head_wid;
               end
            end
         end
         DELAY: begin
            if (cnt == CNT_W'(1)) fire = 1'b1;
            else                  cnt_nxt = cnt - CNT_W'(1);
         end
         ACTIVE: begin
            if (cnt == CNT_W'(1)) begin
               pulse_nxt = '0;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (fire) begin
         if (fire_wid != '0) begin
            state_nxt = ACTIVE;
            pulse_nxt = ch_dec(fire_ch);
            cnt_nxt   = CNT_W'(fire_wid);
         end else begin
            sticky_nxt = sticky ^ ch_dec(fire_ch);
            done_nxt   = 1'b1;
            state_nxt  = IDLE;
         end
      end
   end

   always_comb begin
      busy    = (state != IDLE);
      evt_out = IDLE_VAL ^ sticky ^ pulse_mask;
   end

endmodule
